// File: rtl/ram_pkg.sv
// ram_sp_param shared definitions: FSM state codes
// and the address-width helper.
package ram_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_sp_core.sv
// ram_sp_core: bare storage array, one address,
// synchronous write and registered read.
module ram_sp_core
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write port and registered read port share addr
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_sp_param.sv
// ram_sp_param: single-port RAM with clear engine.
// RAM_OUT_REG_EN adds a second output register.
module ram_sp_param
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              in_range;
  logic              user_wr;
  logic              user_rd;
  logic              core_we;
  logic              core_re;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              rd_valid;
  logic              rd_zero;
  logic [DATA_W-1:0] dout1;

  assign busy     = (state == ST_CLEAR);
  assign in_range = {1'b0, addr} < DEPTH_L;
  assign user_wr  = !busy && en && wen;
  assign user_rd  = !busy && en && !wen;

  assign core_we    = busy || (user_wr && in_range);
  assign core_re    = user_rd && in_range;
  assign core_addr  = busy ? ptr : addr;
  assign core_wdata = busy ? INIT_VAL : din;

  ram_sp_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .re    (core_re),
    .addr  (core_addr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  // clear engine: sweep ptr over every word
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // read strobe; rd_zero masks the unreset
  // array output after reset and on bad addr
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      rd_valid <= user_rd;
      if (user_rd) rd_zero <= !in_range;
    end
  end

  assign dout1 = rd_zero ? '0 : core_rdata;

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;

  // extra output stage, data and strobe together
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout1;
      valid_q <= rd_valid;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
`else
  assign dout       = dout1;
  assign dout_valid = rd_valid;
`endif

endmodule

// File: tb/tb_ram_sp_param.sv
// tb_ram_sp_param: random and directed stimulus
// on DEPTH=16 and DEPTH=10 instances vs a model.
module tb_ram_sp_param;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       wen;
  logic       clr;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout16;
  logic [7:0] dout10;
  logic       dv16;
  logic       dv10;
  logic       busy16;
  logic       busy10;

  always #5 clk = ~clk;

  ram_sp_param #(
    .DATA_W   (8),
    .DEPTH    (16),
    .INIT_VAL (8'h00)
  ) u16 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .wen        (wen),
    .addr       (addr),
    .din        (din),
    .clr        (clr),
    .dout       (dout16),
    .dout_valid (dv16),
    .busy       (busy16)
  );

  ram_sp_param #(
    .DATA_W   (8),
    .DEPTH    (10),
    .INIT_VAL (8'hC3)
  ) u10 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .wen        (wen),
    .addr       (addr),
    .din        (din),
    .clr        (clr),
    .dout       (dout10),
    .dout_valid (dv10),
    .busy       (busy10)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // model: memory image, remaining clear cycles,
  // and a two-deep result delay line per instance
  int         depth [2] = '{16, 10};
  logic [7:0] init  [2] = '{8'h00, 8'hC3};
  logic [7:0] mm    [2][16];
  int         rem   [2];
  logic [7:0] s1d   [2];
  logic [7:0] s2d   [2];
  logic       s1v   [2];
  logic       s2v   [2];

  task automatic model_edge();
    logic [7:0] nd;
    logic       nv;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        rem[k] = depth[k];
        s1d[k] = '0;
        s1v[k] = 1'b0;
        s2d[k] = '0;
        s2v[k] = 1'b0;
      end else begin
        nd = s1d[k];
        nv = 1'b0;
        if (rem[k] > 0) begin
          mm[k][depth[k] - rem[k]] = init[k];
          rem[k]--;
        end else begin
          if (en && wen && addr < depth[k])
            mm[k][addr] = din;
          if (en && !wen) begin
            nv = 1'b1;
            nd = (addr < depth[k]) ? mm[k][addr] : 8'h00;
          end
          if (clr) rem[k] = depth[k];
        end
        s2d[k] = s1d[k];
        s2v[k] = s1v[k];
        s1d[k] = nd;
        s1v[k] = nv;
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] ed;
    logic       ev;
    for (int k = 0; k < 2; k++) begin
      ed = (LAT == 1) ? s1d[k] : s2d[k];
      ev = (LAT == 1) ? s1v[k] : s2v[k];
      if (k == 0) begin
        check("d16.dout", dout16, ed);
        check("d16.valid", dv16, ev);
        check("d16.busy", busy16, rem[k] > 0);
      end else begin
        check("d10.dout", dout10, ed);
        check("d10.valid", dv10, ev);
        check("d10.busy", busy10, rem[k] > 0);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e,
                     input logic w, input logic [3:0] a,
                     input logic [7:0] d, input logic c);
    @(negedge clk);
    reset = r;
    en    = e;
    wen   = w;
    addr  = a;
    din   = d;
    clr   = c;
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++)
      cyc(1'b0, 1'b1, 1'b0, 4'(a), 8'd0, 1'b0);
    idle(2);
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    wen   = 1'b0;
    addr  = '0;
    din   = '0;
    clr   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0;
      s1d[k] = '0;
      s2d[k] = '0;
      s1v[k] = 1'b0;
      s2v[k] = 1'b0;
      for (int i = 0; i < 16; i++) mm[k][i] = '0;
    end

    // reset pulse, full clear pass, read back
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    idle(16);
    read_all();

    // write then read back-to-back
    cyc(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    idle(2);

    // write with en low, read+clr together,
    // write during busy
    cyc(1'b0, 1'b0, 1'b1, 4'd7, 8'h3C, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'd7, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 4'd7, 8'h3C, 1'b0);
    idle(16);
    cyc(1'b0, 1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    idle(2);

    // out-of-range for DEPTH=10
    cyc(1'b0, 1'b1, 1'b1, 4'd12, 8'hFF, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'd12, 8'h00, 1'b0);
    read_all();

    // fill, clr, second clr mid-pass ignored
    repeat (40)
      cyc(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)),
          8'($urandom), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    idle(4);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    idle(12);
    read_all();

    // reset on the 5th cycle of a clear pass
    repeat (20)
      cyc(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)),
          8'($urandom), 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'd2, 8'd0, 1'b1);
    idle(4);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    idle(17);
    read_all();

    // random mixed traffic
    repeat (800)
      cyc(1'($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)),
          8'($urandom),
          1'($urandom_range(0, 49) == 0));
    idle(17);
    read_all();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
